dmem_responder: RTL and testbench

Data-memory responder for the RV32 core's load/store port. It accepts one request at a time over a valid/ready handshake and holds it for a programmable number of wait cycles. It performs byte, halfword or word access with RISC-V funct3 width encoding and sign or zero extension, then returns a response over a second valid/ready handshake. It replaces the zero-wait combinational data memory when the core is moved to a stalling multicycle datapath.

---
 rtl/dmem_responder.sv | 156 +++++++++++++++
 tb/tb_dmem_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32 load/store port: one request at a time,
// fixed programmable latency, RISC-V width/extension rules, valid/ready on both sides.
module dmem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  // RAM is deliberately outside reset so its contents can be preloaded
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic [AW-1:0] idx;
  logic          oor, misal, bad_f3, fault;
  logic [31:0]   word, ld_data, wr_data;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [3:0]    be;

  // Request decode: fault detection, load extraction and store lane enables
  always_comb begin
    accept  = req_valid && (state_q == S_IDLE);
    idx     = req_addr[AW+1:2];
    oor     = |req_addr[31:AW+2];
    bad_f3  = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
              (req_we && req_funct3[2]);
    misal   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
              ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    fault   = oor || bad_f3 || misal;
    word    = mem[idx];
    ld_half = req_addr[1] ? word[31:16] : word[15:0];
    case (req_addr[1:0])
      2'b00:   ld_byte = word[7:0];
      2'b01:   ld_byte = word[15:8];
      2'b10:   ld_byte = word[23:16];
      default: ld_byte = word[31:24];
    endcase
    case (req_funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = word;
    endcase
    case (req_funct3[1:0])
      2'b00: begin
        be      = 4'b0001 << req_addr[1:0];
        wr_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be      = req_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{req_wdata[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        wr_data = req_wdata;
      end
    endcase
  end

  // Store commits on the acceptance edge; reset blocks acceptance
  always_ff @(posedge clk) begin
    if (!reset && accept && req_we && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic and latency counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d   = CW'(LATENCY - 1);
          state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output next-values; response payload is captured once at acceptance
  always_comb begin
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    rdata_d     = rdata_q;
    err_d       = err_q;
    if (accept) begin
      rdata_d = (req_we || fault) ? 32'h0 : ld_data;
      err_d   = fault;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, multi-cycle corner sequences
// and a randomized run against a word-array reference model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset2, reset4, v2, v4, req_we, rsp_ready, sel;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_f3;
  logic        r2_ready, r4_ready, r2_valid, r4_valid, r2_err, r4_err;
  logic [31:0] r2_rdata, r4_rdata;
  logic        cur_ready, cur_valid, cur_err;
  logic [31:0] cur_rdata;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(256), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset2), .req_valid(v2), .req_ready(r2_ready),
    .req_we(req_we), .req_addr(req_addr), .req_funct3(req_f3), .req_wdata(req_wdata),
    .rsp_valid(r2_valid), .rsp_ready(rsp_ready), .rsp_rdata(r2_rdata), .rsp_err(r2_err));

  dmem_responder #(.DEPTH(256), .LATENCY(4)) u_dut4 (
    .clk(clk), .reset(reset4), .req_valid(v4), .req_ready(r4_ready),
    .req_we(req_we), .req_addr(req_addr), .req_funct3(req_f3), .req_wdata(req_wdata),
    .rsp_valid(r4_valid), .rsp_ready(rsp_ready), .rsp_rdata(r4_rdata), .rsp_err(r4_err));

  assign cur_ready = sel ? r4_ready : r2_ready;
  assign cur_valid = sel ? r4_valid : r2_valid;
  assign cur_rdata = sel ? r4_rdata : r2_rdata;
  assign cur_err   = sel ? r4_err   : r2_err;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wdata;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] model [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [31:0] a, input logic [2:0] f3,
                     input logic [31:0] wd, input int hold, input logic [31:0] er, input logic ee);
    vec_t v;
    v.we = we; v.addr = a; v.f3 = f3; v.wdata = wd; v.hold = hold;
    v.exp_rdata = er; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  // One full transaction; checks latency, backpressure stability and return to idle
  task automatic do_req(input logic s, input logic we, input logic [31:0] a, input logic [2:0] f3,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er);
    int   n;
    logic seen;
    sel = s;
    @(negedge clk);
    check("req_ready_before", 32'(cur_ready), 32'd1);
    req_we = we; req_addr = a; req_f3 = f3; req_wdata = wd;
    if (s) v4 = 1'b1; else v2 = 1'b1;
    rsp_ready = (hold == 0);
    @(posedge clk);
    #1;
    v2 = 1'b0; v4 = 1'b0;
    seen = 1'b0; n = 0;
    while (!seen && n < 12) begin
      @(negedge clk);
      n++;
      if (cur_valid) seen = 1'b1;
    end
    if (!seen) begin
      check("rsp_timeout", 32'(cur_valid), 32'd1);
      rd = '0; er = 1'b0; rsp_ready = 1'b1;
      return;
    end
    check("latency", 32'(n), s ? 32'd4 : 32'd2);
    rd = cur_rdata;
    er = cur_err;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("bp_valid", 32'(cur_valid), 32'd1);
      check("bp_rdata", cur_rdata, rd);
      check("bp_err", 32'(cur_err), 32'(er));
      check("bp_req_ready", 32'(cur_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("post_rsp_valid", 32'(cur_valid), 32'd0);
    check("post_req_ready", 32'(cur_ready), 32'd1);
  endtask

  function automatic logic model_fault(input logic we, input logic [31:0] a, input logic [2:0] f3);
    int unsigned w;
    w = 32'(f3) % 4;
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    if (we && f3 >= 4) return 1'b1;
    if (w == 1 && (a % 2) != 0) return 1'b1;
    if (w == 2 && (a % 4) != 0) return 1'b1;
    if ((a / 4) >= 256) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    logic [31:0] rd, exp_rd, w, v, mask;
    logic        er, exp_er, we, any_valid;
    logic [31:0] a;
    logic [2:0]  f3;
    int          sh, hold;

    sel = 1'b0; v2 = 1'b0; v4 = 1'b0; req_we = 1'b0; rsp_ready = 1'b1;
    req_addr = '0; req_wdata = '0; req_f3 = '0;
    reset2 = 1'b1; reset4 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(r2_ready), 32'd1);
    check("rst_rsp_valid", 32'(r2_valid), 32'd0);
    check("rst_rsp_rdata", r2_rdata, 32'h0);
    check("rst_rsp_err", 32'(r2_err), 32'd0);
    check("rst4_req_ready", 32'(r4_ready), 32'd1);
    check("rst4_rsp_valid", 32'(r4_valid), 32'd0);
    reset2 = 1'b0; reset4 = 1'b0;

    add(1, 32'h64, 3'b010, 32'hDEADBEEF, 0, 32'h0, 0);
    add(0, 32'h64, 3'b010, 32'h0, 5, 32'hDEADBEEF, 0);
    add(1, 32'h60, 3'b010, 32'h80F17F82, 0, 32'h0, 0);
    add(0, 32'h60, 3'b000, 32'h0, 0, 32'hFFFFFF82, 0);
    add(0, 32'h60, 3'b100, 32'h0, 0, 32'h00000082, 0);
    add(0, 32'h61, 3'b000, 32'h0, 0, 32'h0000007F, 0);
    add(0, 32'h62, 3'b001, 32'h0, 0, 32'hFFFF80F1, 0);
    add(0, 32'h62, 3'b101, 32'h0, 0, 32'h000080F1, 0);
    add(0, 32'h60, 3'b001, 32'h0, 0, 32'h00007F82, 0);
    add(0, 32'h63, 3'b000, 32'h0, 0, 32'hFFFFFF80, 0);
    add(0, 32'h62, 3'b100, 32'h0, 0, 32'h000000F1, 0);
    add(1, 32'h20, 3'b010, 32'h11223344, 0, 32'h0, 0);
    add(1, 32'h21, 3'b000, 32'hFFFFFFAA, 0, 32'h0, 0);
    add(1, 32'h22, 3'b001, 32'h1234BEEF, 0, 32'h0, 0);
    add(0, 32'h20, 3'b010, 32'h0, 0, 32'hBEEFAA44, 0);
    add(0, 32'h62, 3'b010, 32'h0, 0, 32'h0, 1);
    add(1, 32'h23, 3'b001, 32'h5555, 0, 32'h0, 1);
    add(0, 32'h20, 3'b010, 32'h0, 0, 32'hBEEFAA44, 0);
    add(0, 32'h400, 3'b010, 32'h0, 0, 32'h0, 1);
    add(1, 32'h400, 3'b010, 32'h1, 0, 32'h0, 1);
    add(0, 32'hFFFFFFFC, 3'b010, 32'h0, 0, 32'h0, 1);
    add(0, 32'h60, 3'b011, 32'h0, 0, 32'h0, 1);
    add(1, 32'h60, 3'b100, 32'h0, 0, 32'h0, 1);
    add(0, 32'h61, 3'b001, 32'h0, 0, 32'h0, 1);
    add(0, 32'h60, 3'b010, 32'h0, 0, 32'h80F17F82, 0);
    add(1, 32'h20, 3'b110, 32'h0, 0, 32'h0, 1);
    add(0, 32'h20, 3'b010, 32'h0, 0, 32'hBEEFAA44, 0);

    foreach (vecs[i]) begin
      do_req(1'b0, vecs[i].we, vecs[i].addr, vecs[i].f3, vecs[i].wdata, vecs[i].hold, rd, er);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
    end

    // Reset coinciding with a request: the store must not happen
    @(negedge clk);
    reset2 = 1'b1; v2 = 1'b1; req_we = 1'b1; req_addr = 32'h64; req_f3 = 3'b010; req_wdata = 32'h0;
    @(negedge clk);
    reset2 = 1'b0; v2 = 1'b0;
    @(negedge clk);
    check("rstreq_valid", 32'(r2_valid), 32'd0);
    check("rstreq_ready", 32'(r2_ready), 32'd1);
    do_req(1'b0, 1'b0, 32'h64, 3'b010, 32'h0, 0, rd, er);
    check("rstreq_mem", rd, 32'hDEADBEEF);

    // LATENCY=4: reset two cycles after accepting a store
    sel = 1'b1;
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h10; req_f3 = 3'b010; req_wdata = 32'h12345678; v4 = 1'b1;
    @(posedge clk);
    #1 v4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset4 = 1'b1;
    @(negedge clk);
    reset4 = 1'b0;
    check("midrst_ready", 32'(r4_ready), 32'd1);
    any_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (r4_valid) any_valid = 1'b1;
    end
    check("midrst_no_valid", 32'(any_valid), 32'd0);
    do_req(1'b1, 1'b0, 32'h10, 3'b010, 32'h0, 0, rd, er);
    check("midrst_commit", rd, 32'h12345678);
    check("midrst_err", 32'(er), 32'd0);

    // Randomized run on words 64..79 against the reference model
    for (int i = 64; i < 80; i++) begin
      w = $urandom;
      model[i] = w;
      do_req(1'b0, 1'b1, 32'(i * 4), 3'b010, w, 0, rd, er);
    end
    for (int t = 0; t < 250; t++) begin
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      a    = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h400) : 32'(32'h100 + $urandom_range(0, 63));
      hold = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
      wd_gen: begin
        req_wdata = $urandom;
      end
      exp_er = model_fault(we, a, f3);
      exp_rd = 32'h0;
      if (!exp_er) begin
        w  = model[a / 4];
        sh = 8 * int'(a % 4);
        if (we) begin
          case (f3)
            3'b000: begin mask = 32'hFF << sh;
                          w = (w & ~mask) | ((req_wdata & 32'hFF) << sh); end
            3'b001: begin sh = 8 * int'(a % 4); mask = 32'hFFFF << sh;
                          w = (w & ~mask) | ((req_wdata & 32'hFFFF) << sh); end
            default: w = req_wdata;
          endcase
          model[a / 4] = w;
        end else begin
          case (f3)
            3'b000: begin v = (w >> sh) & 32'hFF;   exp_rd = (v >= 128)   ? (v | 32'hFFFFFF00) : v; end
            3'b100:       exp_rd = (w >> sh) & 32'hFF;
            3'b001: begin v = (w >> sh) & 32'hFFFF; exp_rd = (v >= 32768) ? (v | 32'hFFFF0000) : v; end
            3'b101:       exp_rd = (w >> sh) & 32'hFFFF;
            default:      exp_rd = w;
          endcase
        end
      end
      do_req(1'b0, we, a, f3, req_wdata, hold, rd, er);
      check($sformatf("rnd%0d_rdata a=%08h f3=%0d we=%0d", t, a, f3, we), rd, exp_rd);
      check($sformatf("rnd%0d_err", t), 32'(er), 32'(exp_er));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
